// File: rtl/aes_byte_host.sv
// Byte-stream host for the 8-bit AES core: loads 16 bytes into plain, pulses start,
// waits for done (optional timeout), then streams the captured result out MSB byte first.
module aes_byte_host #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     plain,
  output logic             aes_start,
  input  logic             aes_done,
  input  logic [127:0]     zipher,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] blocks_done
);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StDrain} state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [127:0]       plain_q, plain_d;
  logic [127:0]       res_q, res_d;
  logic [31:0]        tmo_cnt_q, tmo_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   blocks_q, blocks_d;
  logic               in_fire, out_fire, tmo_hit;
  logic [127:0]       res_shift;

  // Handshake outputs are gated by rst so nothing is offered while reset is held.
  assign in_ready    = !rst && (state_q == StLoad);
  assign aes_start   = !rst && (state_q == StStart);
  assign out_valid   = !rst && (state_q == StDrain);
  assign busy        = !rst && !((state_q == StLoad) && (idx_q == 4'd0));
  assign plain       = plain_q;
  assign timeout_err = timeout_err_q;
  assign blocks_done = blocks_q;

  assign res_shift = res_q << {idx_q, 3'b000};
  assign out_byte  = out_valid ? res_shift[127:120] : 8'h00;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    plain_d       = plain_q;
    res_d         = res_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    blocks_d      = blocks_q;
    unique case (state_q)
      StLoad: begin
        if (in_fire) begin
          // Byte k lands at bit offset 8*(15-k), so the first byte is the MSB.
          plain_d[{~idx_q, 3'b000} +: 8] = in_byte;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = StStart;
        end
      end
      StStart: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (aes_done) begin
          res_d   = zipher;
          idx_d   = 4'd0;
          state_d = StDrain;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          idx_d         = 4'd0;
          state_d       = StLoad;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      StDrain: begin
        if (out_fire) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            blocks_d = blocks_q + CNT_W'(1);
            state_d  = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StLoad;
      idx_q         <= 4'd0;
      plain_q       <= '0;
      res_q         <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      blocks_q      <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      plain_q       <= plain_d;
      res_q         <= res_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      blocks_q      <= blocks_d;
    end
  end

endmodule
